// File: rtl/acc_dump.sv
// -----------------------------------------------------------------------------
// acc_dump -- integrate-and-dump stage behind the multiply-add datapath.
//
// The block accumulates N consecutive valid signed samples. It then emits one
// rounded, arithmetically right-shifted result of OUT_W bits, together with a
// one-cycle rdy_out pulse. Frames may run back-to-back with no idle cycles, and
// there is no backpressure.
//
// Pipeline:
//   stage 1 : the accumulator FSM. Accepting the Nth sample raises dump_r.
//   stage 2 : on the edge after dump_r, this stage rounds, shifts and fits the
//             accumulator into dout, and pulses rdy_out (and sat).
//
// Optional feature (macro ACC_DUMP_SAT_EN):
//   defined   : the result saturates to the OUT_W signed range, and sat pulses
//               with rdy_out whenever clipping occurred.
//   undefined : the result wraps in two's complement (its low OUT_W bits), and
//               sat stays 0.
//
// Parameters:
//   IN_W  - input sample width (signed)
//   N     - samples per dump, N >= 2
//   ACC_W - accumulator width, >= IN_W + clog2(N)
//   SHIFT - arithmetic right shift applied at dump, >= 1
//   OUT_W - output width (signed)
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   s_in    in   IN_W   signed sample
//   val_in  in   1      s_in valid this cycle
//   clr     in   1      synchronous flush of the partial frame (wins over val_in)
//   dout    out  OUT_W  registered signed result; holds its value between dumps
//   rdy_out out  1      one-cycle pulse, dout valid
//   sat     out  1      one-cycle pulse aligned with rdy_out, dout was clipped
// -----------------------------------------------------------------------------
module acc_dump #(
  parameter int IN_W  = 16,
  parameter int N     = 4,
  parameter int ACC_W = 18,
  parameter int SHIFT = 10,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  s_in,
  input  logic                    val_in,
  input  logic                    clr,
  output logic signed [OUT_W-1:0] dout,
  output logic                    rdy_out,
  output logic                    sat
);

  // Reject illegal configurations at elaboration time.
  // For example, N=1 would need a frame that starts and dumps on the same edge.
  if (N < 2) begin : g_bad_n
    $fatal(1, "acc_dump: N must be >= 2 (got %0d)", N);
  end
  if (ACC_W < IN_W + $clog2(N)) begin : g_bad_acc_w
    $fatal(1, "acc_dump: ACC_W too narrow for IN_W and N");
  end
  if (SHIFT < 1) begin : g_bad_shift
    $fatal(1, "acc_dump: SHIFT must be >= 1");
  end

  // The counter only ever holds 0..N-1.
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Rounding constant 2^(SHIFT-1), and the output range, all in ACC_W+1 bits.
  localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;  // ~x == -x-1

  typedef enum logic {
    IDLE = 1'b0,  // no partial frame
    ACC  = 1'b1   // 1..N-1 samples held
  } state_t;

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic                     dump_r, dump_next;

  logic signed [ACC_W-1:0]  s_ext;
  logic signed [ACC_W:0]    r_sum;
  logic signed [ACC_W:0]    r_shift;
  logic [OUT_W-1:0]         fit;
  logic                     clip;

  assign s_ext = {{(ACC_W - IN_W){s_in[IN_W-1]}}, s_in};

  // ---------------------------------------------------------------------------
  // Stage 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop here
  // samples pre-edge values; stage 2 relies on this to read the old acc while
  // a new frame loads on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      dump_r <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      dump_r <= dump_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    dump_next  = 1'b0;

    if (clr) begin
      // Drop the partial frame, and any sample offered with it. acc is left
      // alone so that a dump already flagged in dump_r still reads the right
      // sum. The next frame reloads acc from IDLE anyway.
      state_next = IDLE;
      cnt_next   = '0;
    end else if (val_in) begin
      unique case (state)
        IDLE: begin
          acc_next   = s_ext;
          cnt_next   = CNT_W'(1);
          state_next = ACC;
        end
        ACC: begin
          acc_next = acc + s_ext;
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            dump_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output logic -- round half toward +inf, shift, fit to OUT_W
  // ---------------------------------------------------------------------------
  always_comb begin
    r_sum   = {acc[ACC_W-1], acc} + HALF;
    r_shift = r_sum >>> SHIFT;
`ifdef ACC_DUMP_SAT_EN
    if (r_shift > OUT_MAX) begin
      fit  = OUT_MAX[OUT_W-1:0];
      clip = 1'b1;
    end else if (r_shift < OUT_MIN) begin
      fit  = OUT_MIN[OUT_W-1:0];
      clip = 1'b1;
    end else begin
      fit  = r_shift[OUT_W-1:0];
      clip = 1'b0;
    end
`else
    fit  = r_shift[OUT_W-1:0];
    clip = 1'b0;
`endif
  end

`ifndef ACC_DUMP_SAT_EN
  // In the wrapping build, the high bits of the shifted sum are dropped.
  logic unused_hi;
  assign unused_hi = ^r_shift[ACC_W:OUT_W];
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dout    <= '0;
      rdy_out <= 1'b0;
      sat     <= 1'b0;
    end else begin
      rdy_out <= dump_r;
      sat     <= dump_r & clip;
      if (dump_r) begin
        dout <= fit;
      end
    end
  end

endmodule

// File: tb/tb_acc_dump.sv
// -----------------------------------------------------------------------------
// tb_acc_dump -- self-checking bench for acc_dump (N=4, SHIFT=2).
//
// The reference model works per frame. It keeps the accepted samples of the
// current frame in a queue, sums them once N have arrived, and converts the sum
// with plain integer arithmetic. The expected result is then due one edge later.
//
// The rejection of N=1 happens at elaboration, inside the design, so no
// instance with N=1 is built here.
// -----------------------------------------------------------------------------
module tb_acc_dump;

  localparam int IN_W  = 16;
  localparam int N     = 4;
  localparam int ACC_W = 18;
  localparam int SHIFT = 2;
  localparam int OUT_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [IN_W-1:0]  s_in;
  logic                    val_in;
  logic                    clr;
  logic signed [OUT_W-1:0] dout;
  logic                    rdy_out;
  logic                    sat;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int frame_q[$];
  bit pend_valid = 1'b0;
  int pend_dout  = 0;
  int pend_sat   = 0;
  int exp_dout   = 0;
  int exp_rdy    = 0;
  int exp_sat    = 0;

  acc_dump #(
    .IN_W (IN_W),
    .N    (N),
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_in   (s_in),
    .val_in (val_in),
    .clr    (clr),
    .dout   (dout),
    .rdy_out(rdy_out),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Convert a frame sum into the expected (dout, sat) pair.
  // The rounding step is floor((sum + 2^(SHIFT-1)) / 2^SHIFT).
  task automatic convert(input longint sum, output int d, output int s);
    longint num, den, q, w;
    num = sum + (longint'(1) << (SHIFT - 1));
    den = longint'(1) << SHIFT;
    q   = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;  // floor for negatives
`ifdef ACC_DUMP_SAT_EN
    if (q > 127) begin
      d = 127;  s = 1;
    end else if (q < -128) begin
      d = -128; s = 1;
    end else begin
      d = int'(q); s = 0;
    end
`else
    w = q & 64'hFF;
    if (w >= 128) w = w - 256;
    d = int'(w);
    s = 0;
`endif
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare
  // the outputs shortly after the edge.
  task automatic step(input bit v, input int s, input bit c, input bit r);
    longint sum;
    val_in = v;
    s_in   = IN_W'(s);
    clr    = c;
    rst    = r;
    @(posedge clk);
    if (r) begin
      frame_q.delete();
      pend_valid = 1'b0;
      exp_dout   = 0;
      exp_rdy    = 0;
      exp_sat    = 0;
    end else begin
      exp_rdy = pend_valid ? 1 : 0;
      exp_sat = pend_valid ? pend_sat : 0;
      if (pend_valid) exp_dout = pend_dout;
      pend_valid = 1'b0;
      if (c) begin
        frame_q.delete();
      end else if (v) begin
        frame_q.push_back(s);
        if (frame_q.size() == N) begin
          sum = 0;
          foreach (frame_q[i]) sum += frame_q[i];
          convert(sum, pend_dout, pend_sat);
          pend_valid = 1'b1;
          frame_q.delete();
        end
      end
    end
    #1;
    check("rdy_out", int'(rdy_out), exp_rdy);
    check("sat", int'(sat), exp_sat);
    check("dout", int'(dout), exp_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; val_in = 1'b0; s_in = '0; clr = 1'b0;
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    check("reset_dout", int'(dout), 0);
    check("reset_rdy", int'(rdy_out), 0);
    idle(2);

    // Basic sum: 10,20,30,40 -> 25.
    step(1, 10, 0, 0); step(1, 20, 0, 0); step(1, 30, 0, 0); step(1, 40, 0, 0);
    step(0, 0, 0, 0);
    check("basic_dout", int'(dout), 25);
    check("basic_rdy", int'(rdy_out), 1);
    idle(2);

    // Rounding: four -3 -> -3; then -1,0,0,0 -> 0.
    for (int i = 0; i < 4; i++) step(1, -3, 0, 0);
    step(0, 0, 0, 0);
    check("round_neg", int'(dout), -3);
    step(1, -1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("round_half", int'(dout), 0);
    idle(2);

    // Saturation / wrap: four 32767.
    for (int i = 0; i < 4; i++) step(1, 32767, 0, 0);
    step(0, 0, 0, 0);
`ifdef ACC_DUMP_SAT_EN
    check("sat_dout", int'(dout), 127);
    check("sat_flag", int'(sat), 1);
`else
    check("wrap_dout", int'(dout), -1);
    check("wrap_flag", int'(sat), 0);
`endif
    idle(2);

    // Gaps then back-to-back: eight ones -> two pulses of 1.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(3));
      step(1, 1, 0, 0);
      pulses += int'(rdy_out);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      pulses += int'(rdy_out);
      if (i == 0) check("b2b_first_dout", int'(dout), 1);
    end
    step(0, 0, 0, 0);
    pulses += int'(rdy_out);
    check("b2b_second_dout", int'(dout), 1);
    check("b2b_pulses", pulses, 2);
    idle(2);

    // Flush: 100,100, clr+50, then four 4 -> one pulse, dout=4.
    pulses = 0;
    step(1, 100, 0, 0); step(1, 100, 0, 0); step(1, 50, 1, 0);
    pulses += int'(rdy_out);
    for (int i = 0; i < 4; i++) begin
      step(1, 4, 0, 0);
      pulses += int'(rdy_out);
    end
    step(0, 0, 0, 0);
    pulses += int'(rdy_out);
    check("flush_dout", int'(dout), 4);
    check("flush_pulses", pulses, 1);
    idle(2);

    // Reset mid-frame: three 500, rst, then four 8 -> 8.
    for (int i = 0; i < 3; i++) step(1, 500, 0, 0);
    step(0, 0, 0, 1);
    check("rst_mid_dout", int'(dout), 0);
    check("rst_mid_rdy", int'(rdy_out), 0);
    for (int i = 0; i < 4; i++) step(1, 8, 0, 0);
    step(0, 0, 0, 0);
    check("after_rst_dout", int'(dout), 8);
    idle(2);

    // Randomised traffic: gaps, occasional flush and reset, mixed magnitudes.
    for (int i = 0; i < 3000; i++) begin
      int v, s, c, r;
      v = ($urandom_range(99) < 75) ? 1 : 0;
      c = ($urandom_range(99) < 3) ? 1 : 0;
      r = ($urandom_range(999) < 5) ? 1 : 0;
      case ($urandom_range(3))
        0:       s = 32767 - $urandom_range(3);
        1:       s = -32768 + $urandom_range(3);
        2:       s = $urandom_range(40) - 20;
        default: s = $urandom_range(65535) - 32768;
      endcase
      step(v[0], s, c[0], r[0]);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
